c3aibadapt_sr_capture_ctrl: RTL and testbench

Sequencer for the sideband status-capture path. It pulses `unload` to the async capture buses and waits a programmable settle window while they resample. It then parallel-loads their captured word into a shift register and streams it LSB-first onto the sideband serial chain under downstream shift-enable control. It sits between the capture-bus bank and the sideband serializer, in the `clk` domain of the capture buses.

---
 rtl/c3aibadapt_sr_pkg.sv | 31 +++
 rtl/c3aibadapt_sr_piso.sv | 54 +++++
 rtl/c3aibadapt_sr_capture_ctrl.sv | 160 ++++++++++++++++
 tb/tb_c3aibadapt_sr_capture_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3aibadapt_sr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c3aibadapt_sr_pkg
// Purpose  : Shared types and constants for the sideband status-capture
//            sequencer (FSM state encoding, settle-window limits, helpers).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package c3aibadapt_sr_pkg;

    // Capture/shift sequencer states, fixed 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNLOAD = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SHIFT  = 3'd4,
        ST_DONE   = 3'd5
    } sr_state_e;

    // Smallest settle window that still covers bitsync latency plus the
    // 3-sample stability window of the capture buses.
    localparam int SR_SETTLE_MIN = 4;

    // The settle counter is 8 bits wide and is loaded with SETTLE_CYC-1.
    function automatic bit sr_settle_legal(input int settle_cyc);
        return (settle_cyc >= 1) && (settle_cyc <= 255);
    endfunction

endpackage
`default_nettype wire

// File: rtl/c3aibadapt_sr_piso.sv
`default_nettype none
// ============================================================================
// Module   : c3aibadapt_sr_piso
// Purpose  : DWIDTH-bit parallel-load / serial-out register, LSB first,
//            zero fill on shift. Flags the first bit of a word (sof) and
//            decodes the last bit from the caller's bit counter (last).
// Ports    : clk, rst      - clock, synchronous active-high reset
//            load_i        - parallel load data_i (takes priority)
//            shift_i       - shift right by one, zero fill
//            data_i        - parallel word
//            cnt_i         - remaining-bit counter owned by the sequencer
//            dout_o        - current serial bit (register bit 0)
//            sof_o         - registered: current bit is bit 0 of the word
//            last_o        - current bit is the last of the word
// Revision : 1.0 - initial release
// ============================================================================
module c3aibadapt_sr_piso #(
    parameter int DWIDTH = 16,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic [CW-1:0]     cnt_i,
    output logic              dout_o,
    output logic              sof_o,
    output logic              last_o
);

    logic [DWIDTH-1:0] shreg_q;
    logic              sof_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            sof_q   <= 1'b0;
        end else if (load_i) begin
            shreg_q <= data_i;
            sof_q   <= 1'b1;
        end else if (shift_i) begin
            shreg_q <= shreg_q >> 1;
            // Only the first accepted bit carries sof; a stall keeps it set.
            sof_q   <= 1'b0;
        end
    end

    assign dout_o = shreg_q[0];
    assign sof_o  = sof_q;
    assign last_o = (cnt_i == '0);

endmodule
`default_nettype wire

// File: rtl/c3aibadapt_sr_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : c3aibadapt_sr_capture_ctrl
// Purpose  : Sideband status-capture sequencer. Pulses unload to the capture
//            buses, waits SETTLE_CYC cycles, parallel-loads capt_data and
//            streams it LSB first under shift_en control.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start             - request one sequence (IDLE only)
//            r_cont            - continuous re-arm after each word
//            r_capt_mode_in    - capture mode config, registered to r_capt_mode
//            capt_data         - captured word from the capture-bus bank
//            shift_en          - downstream accepts the presented bit
//            unload            - one-cycle clear pulse to the capture buses
//            r_capt_mode       - registered capture mode
//            sr_dout/vld/sof   - serial bit, valid, start-of-word marker
//            busy              - sequence in progress
//            done              - one-cycle pulse after the last bit
// Revision : 1.0 - initial release
// ============================================================================
module c3aibadapt_sr_capture_ctrl
    import c3aibadapt_sr_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              r_cont,
    input  logic              r_capt_mode_in,
    input  logic [DWIDTH-1:0] capt_data,
    input  logic              shift_en,
    output logic              unload,
    output logic              r_capt_mode,
    output logic              sr_dout,
    output logic              sr_vld,
    output logic              sr_sof,
    output logic              busy,
    output logic              done
);

    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    // Elaboration-time parameter checks.
    if (!sr_settle_legal(SETTLE_CYC)) begin : g_bad_settle
        $error("SETTLE_CYC must be within 1..255");
    end
    if (SETTLE_CYC < SR_SETTLE_MIN) begin : g_short_settle
        $warning("SETTLE_CYC is below the capture-bus stability window");
    end
    if ((DWIDTH < 1) || (DWIDTH > 256)) begin : g_bad_dwidth
        $error("DWIDTH must be within 1..256");
    end

    sr_state_e   state_q, state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;

    logic unload_q, busy_q, done_q, vld_q, capt_mode_q;
    logic piso_load, piso_shift, piso_last, piso_sof, piso_dout;

    assign piso_load  = (state_q == ST_LOAD);
    assign piso_shift = (state_q == ST_SHIFT) && shift_en;

    c3aibadapt_sr_piso #(
        .DWIDTH (DWIDTH),
        .CW     (CW)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .data_i  (capt_data),
        .cnt_i   (bit_cnt_q),
        .dout_o  (piso_dout),
        .sof_o   (piso_sof),
        .last_o  (piso_last)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start || r_cont) begin
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = 8'(SETTLE_CYC - 1);
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 8'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            ST_LOAD: begin
                state_d   = ST_SHIFT;
                bit_cnt_d = CW'(DWIDTH - 1);
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    // The counter is left at zero on the last bit so it
                    // never wraps; LOAD reloads it for the next word.
                    if (piso_last) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = r_cont ? ST_UNLOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe, with no input-to-output paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= 8'd0;
            bit_cnt_q    <= '0;
            unload_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vld_q        <= 1'b0;
            capt_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            unload_q     <= (state_d == ST_UNLOAD);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            vld_q        <= (state_d == ST_SHIFT);
            capt_mode_q  <= r_capt_mode_in;
        end
    end

    assign unload      = unload_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sr_vld      = vld_q;
    assign sr_dout     = piso_dout;
    // The piso flag is set at LOAD and cleared by the first accepted shift,
    // so it is only ever high while SHIFT presents bit 0.
    assign sr_sof      = piso_sof;
    assign r_capt_mode = capt_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_c3aibadapt_sr_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_c3aibadapt_sr_capture_ctrl
// Purpose  : Scoreboard bench for the status-capture sequencer. Stimulus
//            pushes expected unload / bit / done events with their cycle;
//            a negedge monitor pops and compares whenever the DUT shows one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c3aibadapt_sr_capture_ctrl;

    localparam int DW = 16;
    localparam int SC = 8;

    localparam int K_UNLOAD = 0;
    localparam int K_BIT    = 1;
    localparam int K_DONE   = 2;

    typedef struct {
        int   kind;
        logic val;
        logic sof;
        int   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          r_cont;
    logic          r_capt_mode_in;
    logic [DW-1:0] capt_data;
    logic          shift_en;
    logic          unload, r_capt_mode, sr_dout, sr_vld, sr_sof, busy, done;

    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t exp_q[$];
    int   stall_q[$];

    // Hand-computed LSB-first streams.
    bit w_a5c3 [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    bit w_0001 [16] = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

    c3aibadapt_sr_capture_ctrl #(
        .DWIDTH     (DW),
        .SETTLE_CYC (SC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .r_cont         (r_cont),
        .r_capt_mode_in (r_capt_mode_in),
        .capt_data      (capt_data),
        .shift_en       (shift_en),
        .unload         (unload),
        .r_capt_mode    (r_capt_mode),
        .sr_dout        (sr_dout),
        .sr_vld         (sr_vld),
        .sr_sof         (sr_sof),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            K_UNLOAD: return "unload";
            K_BIT:    return "bit";
            default:  return "done";
        endcase
    endfunction

    function automatic bit is_stall(input int c);
        foreach (stall_q[i]) if (stall_q[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Expected events for one word whose unload is at cycle e. Bits that
    // fall on stalled cycles slip by one cycle each. Returns the done cycle.
    function automatic int push_word(input bit bits [16], input int e, input int nbits);
        exp_t x;
        int   t;
        x = '{kind: K_UNLOAD, val: 1'b0, sof: 1'b0, cyc: e};
        exp_q.push_back(x);
        t = e + SC + 2;
        for (int i = 0; i < nbits; i++) begin
            while (is_stall(t)) t++;
            x = '{kind: K_BIT, val: bits[i], sof: (i == 0), cyc: t};
            exp_q.push_back(x);
            t++;
        end
        if (nbits == DW) begin
            x = '{kind: K_DONE, val: 1'b0, sof: 1'b0, cyc: t};
            exp_q.push_back(x);
        end
        return t;
    endfunction

    task automatic pop_check(input int kind, input logic val, input logic sof);
        exp_t e;
        if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_%s at cyc %0d: got event, required none", kname(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        chk({kname(kind), "_kind"}, kind, e.kind);
        chk({kname(kind), "_cyc"}, cyc, e.cyc);
        if (kind == K_BIT) begin
            chk("bit_val", val, e.val);
            chk("bit_sof", sof, e.sof);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (unload === 1'b1) pop_check(K_UNLOAD, 1'b0, 1'b0);
            if (sr_vld === 1'b1) begin
                if (shift_en) begin
                    pop_check(K_BIT, sr_dout, sr_sof);
                end else if (exp_q.size() > 0 && exp_q[0].kind == K_BIT) begin
                    chk("stall_val", sr_dout, exp_q[0].val);
                    chk("stall_sof", sr_sof, exp_q[0].sof);
                end else begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_vld at cyc %0d: got sr_vld 1, required 0", cyc);
                end
            end
            if (done === 1'b1) pop_check(K_DONE, 1'b0, 1'b0);
        end
    end

    // Downstream shift-enable driver
    initial begin
        shift_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            shift_en = !is_stall(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stepto(input int target);
        while (cyc < target) step(1);
    endtask

    initial begin
        int e, d, d2;
        rst            = 1'b1;
        start          = 1'b1;
        r_cont         = 1'b0;
        r_capt_mode_in = 1'b0;
        capt_data      = 16'hA5C3;

        // Reset held three edges with start high: everything stays low.
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_unload", unload, 0);
            chk("rst_dout", sr_dout, 0);
            chk("rst_vld", sr_vld, 0);
            chk("rst_sof", sr_sof, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_capt_mode", r_capt_mode, 0);
            if (i < 2) step(1);
        end
        rst = 1'b0;
        e = cyc + 1;
        d = push_word(w_a5c3, e, DW);
        step(1);
        start = 1'b0;
        stepto(d + 4);
        chk("idle_busy", busy, 0);

        // Capture-mode forwarding.
        r_capt_mode_in = 1'b1;
        step(1);
        chk("capt_mode_hi", r_capt_mode, 1);
        r_capt_mode_in = 1'b0;
        step(1);
        chk("capt_mode_lo", r_capt_mode, 0);

        // Backpressure on bits 3 and 9, two cycles each.
        e = cyc + 1;
        stall_q = '{e + 13, e + 14, e + 21, e + 22};
        start = 1'b1;
        d = push_word(w_a5c3, e, DW);
        chk("bp_done_cycle", d - e + 1, 31);
        step(1);
        start = 1'b0;
        stepto(d + 4);
        stall_q.delete();

        // Start pulses during SETTLE and SHIFT are ignored.
        e = cyc + 1;
        start = 1'b1;
        d = push_word(w_a5c3, e, DW);
        step(1);
        start = 1'b0;
        stepto(e + 5);
        chk("settle_busy", busy, 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        stepto(e + 15);
        start = 1'b1;
        step(1);
        start = 1'b0;
        stepto(d + 6);

        // Continuous mode, second word sees the new capt_data.
        e = cyc + 1;
        r_cont = 1'b1;
        start  = 1'b1;
        d  = push_word(w_a5c3, e, DW);
        d2 = push_word(w_0001, d + 1, DW);
        step(1);
        start = 1'b0;
        stepto(e + 15);
        capt_data = 16'h0001;
        stepto(e + 40);
        r_cont = 1'b0;
        stepto(d2 + 4);
        capt_data = 16'hA5C3;
        chk("cont_idle_busy", busy, 0);

        // Abort with reset at bit 5, then a clean word.
        e = cyc + 1;
        start = 1'b1;
        d = push_word(w_a5c3, e, 6);
        step(1);
        start = 1'b0;
        stepto(e + 15);
        rst = 1'b1;
        step(1);
        chk("abort_busy", busy, 0);
        chk("abort_vld", sr_vld, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        step(3);
        chk("abort_drained", exp_q.size(), 0);
        e = cyc + 1;
        start = 1'b1;
        d = push_word(w_a5c3, e, DW);
        step(1);
        start = 1'b0;
        stepto(d + 4);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
